// File: rtl/iq_pkg.sv
// Shared types and MIPS32 encoding constants for the dual-issue instruction queue.
package iq_pkg;

    typedef enum logic [2:0] {
        ALU    = 3'd0,
        MEM    = 3'd1,
        MULDIV = 3'd2,
        BRANCH = 3'd3,
        SOLO   = 3'd4
    } iqClass_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        iqClass_e    cls;
        logic [4:0]  dst;
    } iqEntry_s;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_BLEZ     = 6'h06;
    localparam logic [5:0] OP_BGTZ     = 6'h07;
    localparam logic [5:0] OP_COP0     = 6'h10;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1c;
    localparam logic [5:0] OP_SPECIAL3 = 6'h1f;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MOVZ  = 6'h0a;
    localparam logic [5:0] FN_MOVN  = 6'h0b;
    localparam logic [5:0] FN_SYNC  = 6'h0f;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    localparam logic [5:0] FN_MADD  = 6'h00;
    localparam logic [5:0] FN_MADDU = 6'h01;
    localparam logic [5:0] FN_MUL   = 6'h02;
    localparam logic [5:0] FN_MSUB  = 6'h04;
    localparam logic [5:0] FN_MSUBU = 6'h05;
    localparam logic [5:0] FN_CLZ   = 6'h20;
    localparam logic [5:0] FN_CLO   = 6'h21;

    localparam logic [5:0] FN_EXT   = 6'h00;
    localparam logic [5:0] FN_INS   = 6'h04;
    localparam logic [5:0] FN_BSHFL = 6'h20;
    localparam logic [4:0] SA_WSBH  = 5'h02;
    localparam logic [4:0] SA_SEB   = 5'h10;
    localparam logic [4:0] SA_SEH   = 5'h18;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    localparam logic [4:0] RS_MF     = 5'h00;

endpackage

// File: rtl/iq_predecode.sv
// Enqueue-time predecode: classifies one MIPS32 word for pairing and extracts its GPR destination.
module iq_predecode
    import iq_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  cls,
    output logic [4:0]  dst
);

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sa;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign sa     = instr[10:6];
    assign funct  = instr[5:0];

    // Anything not matched below stays SOLO with no destination.
    always_comb begin
        cls = SOLO;
        dst = 5'd0;
        if (opcode[5:3] == 3'b100) begin
            cls = MEM;
            dst = rt;
        end else if (opcode[5:3] == 3'b101) begin
            cls = MEM;
        end else if (opcode[5:3] == 3'b001) begin
            cls = ALU;
            dst = rt;
        end else begin
            case (opcode)
                OP_SPECIAL: begin
                    dst = rd;
                    case (funct)
                        FN_JR, FN_JALR: cls = BRANCH;
                        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: cls = MULDIV;
                        FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                        FN_MOVZ, FN_MOVN, FN_SYNC,
                        FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                        FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: cls = ALU;
                        default: cls = SOLO;
                    endcase
                end
                OP_REGIMM: begin
                    case (rt)
                        RT_BLTZ, RT_BGEZ: cls = BRANCH;
                        RT_BLTZAL, RT_BGEZAL: begin
                            cls = BRANCH;
                            dst = 5'd31;
                        end
                        default: cls = SOLO;
                    endcase
                end
                OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = BRANCH;
                OP_JAL: begin
                    cls = BRANCH;
                    dst = 5'd31;
                end
                OP_COP0: begin
                    if (rs == RS_MF) dst = rt;
                end
                OP_SPECIAL2: begin
                    case (funct)
                        FN_MADD, FN_MADDU, FN_MSUB, FN_MSUBU: cls = MULDIV;
                        FN_MUL: begin
                            cls = MULDIV;
                            dst = rd;
                        end
                        FN_CLZ, FN_CLO: begin
                            cls = ALU;
                            dst = rd;
                        end
                        default: cls = SOLO;
                    endcase
                end
                OP_SPECIAL3: begin
                    case (funct)
                        FN_EXT, FN_INS: begin
                            cls = ALU;
                            dst = rt;
                        end
                        FN_BSHFL: begin
                            if (sa == SA_WSBH || sa == SA_SEB || sa == SA_SEH) begin
                                cls = ALU;
                                dst = rd;
                            end
                        end
                        default: cls = SOLO;
                    endcase
                end
                default: cls = SOLO;
            endcase
        end
    end

endmodule

// File: rtl/inst_queue_dual_issue.sv
// Circular fetch-to-decode instruction queue with predecode at enqueue and MIPS32 dual-issue pairing.
module inst_queue_dual_issue
    import iq_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int FETCH_W    = 2,
    parameter int DUAL_ISSUE = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic [FETCH_W-1:0]        enq_valid,
    input  logic [FETCH_W*32-1:0]     enq_pc,
    input  logic [FETCH_W*32-1:0]     enq_instr,
    output logic                      enq_ready,
    input  logic                      deq_ready,
    output logic [1:0]                issue_valid,
    output logic [63:0]               issue_pc,
    output logic [63:0]               issue_instr,
    output logic [5:0]                issue_class,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    iqEntry_s         mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] headNext1;
    logic [2:0]       laneCls [FETCH_W];
    logic [4:0]       laneDst [FETCH_W];
    logic             doEnq;
    logic [CNT_W-1:0] enqN;
    logic [CNT_W-1:0] deqN;
    iqEntry_s         slot0;
    iqClass_e         cls1;
    logic [31:0]      instr1;
    logic             rawHazard;
    logic             pairOk;

    function automatic logic [CNT_W-1:0] popCount(input logic [1:0] v);
        return CNT_W'(v[0]) + CNT_W'(v[1]);
    endfunction

    for (genvar g = 0; g < FETCH_W; g++) begin : gLane
        iq_predecode uPredecode (
            .instr (enq_instr[32*g +: 32]),
            .cls   (laneCls[g]),
            .dst   (laneDst[g])
        );
    end

    // Space check uses only registered occupancy, so a same-cycle dequeue never frees room.
    assign enq_ready = (count <= CNT_W'(DEPTH - FETCH_W));
    assign doEnq     = enq_ready && (enq_valid != '0) && !flush;
    assign enqN      = doEnq ? popCount(2'(enq_valid)) : '0;
    assign deqN      = (deq_ready && !flush) ? popCount(issue_valid) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deqN);
            tail  <= tail + PTR_W'(enqN);
            count <= count + enqN - deqN;
        end
    end

    // Entry storage carries no reset; occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        if (doEnq) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (enq_valid[i]) begin
                    mem[tail + PTR_W'(i)] <= '{
                        pc:    enq_pc[32*i +: 32],
                        instr: enq_instr[32*i +: 32],
                        cls:   iqClass_e'(laneCls[i]),
                        dst:   laneDst[i]
                    };
                end
            end
        end
    end

    assign headNext1 = head + PTR_W'(1);

    // rs and rt of slot1 are both treated as sources even for forms that do not read them.
    always_comb begin
        slot0     = mem[head];
        cls1      = mem[headNext1].cls;
        instr1    = mem[headNext1].instr;
        rawHazard = (slot0.dst != 5'd0) &&
                    ((slot0.dst == instr1[25:21]) || (slot0.dst == instr1[20:16]));
        pairOk    = (slot0.cls != SOLO) && (cls1 != SOLO) &&
                    !((slot0.cls == MEM) && (cls1 == MEM)) &&
                    !((slot0.cls == MULDIV) && (cls1 == MULDIV)) &&
                    (cls1 != BRANCH) && !rawHazard;
    end

    assign issue_valid[0] = (count != '0);
    assign issue_valid[1] = (DUAL_ISSUE != 0) && (count >= CNT_W'(2)) && pairOk;
    assign issue_pc       = {mem[headNext1].pc, slot0.pc};
    assign issue_instr    = {instr1, slot0.instr};
    assign issue_class    = {cls1, slot0.cls};

endmodule

// File: tb/tb_inst_queue_dual_issue.sv
// Bench for inst_queue_dual_issue: directed table, corner sequences and a randomized queue model.
module tb_inst_queue_dual_issue;

    localparam int DEPTH   = 16;
    localparam int FETCH_W = 2;

    localparam logic [2:0] C_ALU = 3'd0, C_MEM = 3'd1, C_MULDIV = 3'd2, C_BRANCH = 3'd3, C_SOLO = 3'd4;

    localparam logic [31:0] I_ADDU  = 32'h00221821;  // addu $3,$1,$2
    localparam logic [31:0] I_ORI   = 32'h34850001;  // ori  $5,$4,1
    localparam logic [31:0] I_SUBU  = 32'h00643023;  // subu $6,$3,$4
    localparam logic [31:0] I_LW    = 32'h8D280000;  // lw   $8,0($9)
    localparam logic [31:0] I_SW    = 32'hAD6A0004;  // sw   $10,4($11)
    localparam logic [31:0] I_BEQ   = 32'h10220004;  // beq  $1,$2,+4
    localparam logic [31:0] I_ADDIU = 32'h24E70001;  // addiu $7,$7,1
    localparam logic [31:0] I_MTC0  = 32'h40886000;  // mtc0 $8,$12
    localparam logic [31:0] I_NOP   = 32'h00000000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic [1:0]  enqValid;
    logic [63:0] enqPc;
    logic [63:0] enqInstr;
    logic        enqReady;
    logic        deqReady;
    logic [1:0]  issueValid;
    logic [63:0] issuePc;
    logic [63:0] issueInstr;
    logic [5:0]  issueClass;
    logic [4:0]  count;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    inst_queue_dual_issue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .DUAL_ISSUE(1)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .enq_valid   (enqValid),
        .enq_pc      (enqPc),
        .enq_instr   (enqInstr),
        .enq_ready   (enqReady),
        .deq_ready   (deqReady),
        .issue_valid (issueValid),
        .issue_pc    (issuePc),
        .issue_instr (issueInstr),
        .issue_class (issueClass),
        .count       (count)
    );

    // ---------------- reference model: an ordered list of live instructions ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t q[$];

    function automatic logic [2:0] refClass(input logic [31:0] w);
        logic [5:0] op = w[31:26];
        logic [4:0] rt = w[20:16];
        logic [4:0] sa = w[10:6];
        logic [5:0] fn = w[5:0];
        if (op inside {[6'h20:6'h2f]}) return C_MEM;
        if (op inside {[6'h08:6'h0f]}) return C_ALU;
        if (op inside {[6'h02:6'h07]}) return C_BRANCH;
        if (op == 6'h01) return (rt inside {5'h00, 5'h01, 5'h10, 5'h11}) ? C_BRANCH : C_SOLO;
        if (op == 6'h00) begin
            if (fn inside {6'h08, 6'h09}) return C_BRANCH;
            if (fn inside {[6'h10:6'h13], [6'h18:6'h1b]}) return C_MULDIV;
            if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0a, 6'h0b, 6'h0f,
                           [6'h20:6'h27], 6'h2a, 6'h2b}) return C_ALU;
            return C_SOLO;
        end
        if (op == 6'h1c) begin
            if (fn inside {6'h00, 6'h01, 6'h02, 6'h04, 6'h05}) return C_MULDIV;
            if (fn inside {6'h20, 6'h21}) return C_ALU;
            return C_SOLO;
        end
        if (op == 6'h1f) begin
            if (fn inside {6'h00, 6'h04}) return C_ALU;
            if (fn == 6'h20 && (sa inside {5'h02, 5'h10, 5'h18})) return C_ALU;
            return C_SOLO;
        end
        return C_SOLO;
    endfunction

    function automatic logic [4:0] refDst(input logic [31:0] w);
        logic [5:0] op = w[31:26];
        logic [4:0] rs = w[25:21];
        logic [4:0] rt = w[20:16];
        logic [4:0] rd = w[15:11];
        logic [4:0] sa = w[10:6];
        logic [5:0] fn = w[5:0];
        if (op == 6'h00) return rd;
        if (op == 6'h1c && (fn inside {6'h02, 6'h20, 6'h21})) return rd;
        if (op == 6'h1f && fn == 6'h20 && (sa inside {5'h02, 5'h10, 5'h18})) return rd;
        if (op == 6'h03) return 5'd31;
        if (op == 6'h01 && (rt inside {5'h10, 5'h11})) return 5'd31;
        if (op inside {[6'h08:6'h0f], [6'h20:6'h27]}) return rt;
        if (op == 6'h10 && rs == 5'd0) return rt;
        if (op == 6'h1f && (fn inside {6'h00, 6'h04})) return rt;
        return 5'd0;
    endfunction

    function automatic int refIssueN();
        logic [2:0]  ca, cb;
        logic [4:0]  da;
        logic [31:0] b;
        if (q.size() == 0) return 0;
        if (q.size() == 1) return 1;
        ca = refClass(q[0].instr);
        cb = refClass(q[1].instr);
        da = refDst(q[0].instr);
        b  = q[1].instr;
        if (ca == C_SOLO || cb == C_SOLO) return 1;
        if (ca == C_MEM && cb == C_MEM) return 1;
        if (ca == C_MULDIV && cb == C_MULDIV) return 1;
        if (cb == C_BRANCH) return 1;
        if (da != 5'd0 && (da == b[25:21] || da == b[20:16])) return 1;
        return 2;
    endfunction

    task automatic modelEdge();
        int  n;
        bit  room;
        if (flush) begin
            q.delete();
            return;
        end
        room = (q.size() <= DEPTH - FETCH_W);
        n    = deqReady ? refIssueN() : 0;
        repeat (n) void'(q.pop_front());
        if (room) begin
            for (int i = 0; i < FETCH_W; i++)
                if (enqValid[i]) q.push_back('{pc: enqPc[32*i +: 32], instr: enqInstr[32*i +: 32]});
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        int         n = refIssueN();
        logic [1:0] expIv = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".enq_ready"}, 64'(enqReady), 64'(q.size() <= DEPTH - FETCH_W));
        chk({tag, ".issue_valid"}, 64'(issueValid), 64'(expIv));
        if (n >= 1) begin
            chk({tag, ".pc0"}, 64'(issuePc[31:0]), 64'(q[0].pc));
            chk({tag, ".instr0"}, 64'(issueInstr[31:0]), 64'(q[0].instr));
            chk({tag, ".class0"}, 64'(issueClass[2:0]), 64'(refClass(q[0].instr)));
        end
        if (n == 2) begin
            chk({tag, ".pc1"}, 64'(issuePc[63:32]), 64'(q[1].pc));
            chk({tag, ".instr1"}, 64'(issueInstr[63:32]), 64'(q[1].instr));
            chk({tag, ".class1"}, 64'(issueClass[5:3]), 64'(refClass(q[1].instr)));
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with the model advanced.
    task automatic cycle(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] i0,
                         input logic [31:0] p1, input logic [31:0] i1,
                         input logic dr, input logic fl);
        enqValid = v;
        enqPc    = {p1, p0};
        enqInstr = {i1, i0};
        deqReady = dr;
        flush    = fl;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [31:0] pc0, in0, pc1, in1;
        logic        dr;
        logic [1:0]  expIv;
        int          expCnt;
        logic [31:0] expPc0;
        logic [2:0]  expC0, expC1;
    } vec_t;
    vec_t vecs [11];

    logic [31:0] pool [16] = '{
        32'h00000021, 32'h00000023, 32'h34000001, 32'h8C000000,
        32'hAC000000, 32'h10000002, 32'h00000018, 32'h70000002,
        32'h40800000, 32'h0C000010, 32'h04110004, 32'h0000000C,
        32'h00000008, 32'h7C000420, 32'h40000000, 32'h24000005
    };

    function automatic logic [31:0] genInstr();
        logic [31:0] w;
        if ($urandom_range(0, 15) == 0) return $urandom;
        w = pool[$urandom_range(0, 15)];
        w[22:21] = w[22:21] | 2'($urandom_range(0, 3));
        w[17:16] = w[17:16] | 2'($urandom_range(0, 3));
        w[12:11] = w[12:11] | 2'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pcGen;
        logic [1:0]  v;
        logic        dr;
        logic        fl;

        resetn   = 1'b0;
        flush    = 1'b0;
        enqValid = 2'b00;
        enqPc    = '0;
        enqInstr = '0;
        deqReady = 1'b0;

        vecs[0]  = '{2'b11, 32'hBFC00000, I_ADDU, 32'hBFC00004, I_ORI,   1'b1, 2'b11, 2, 32'hBFC00000, C_ALU,    C_ALU};
        vecs[1]  = '{2'b00, 32'h0,        I_NOP,  32'h0,        I_NOP,   1'b1, 2'b00, 0, 32'h0,        C_ALU,    C_ALU};
        vecs[2]  = '{2'b11, 32'h100,      I_ADDU, 32'h104,      I_SUBU,  1'b1, 2'b01, 2, 32'h100,      C_ALU,    C_ALU};
        vecs[3]  = '{2'b00, 32'h0,        I_NOP,  32'h0,        I_NOP,   1'b1, 2'b01, 1, 32'h104,      C_ALU,    C_ALU};
        vecs[4]  = '{2'b00, 32'h0,        I_NOP,  32'h0,        I_NOP,   1'b1, 2'b00, 0, 32'h0,        C_ALU,    C_ALU};
        vecs[5]  = '{2'b11, 32'h200,      I_LW,   32'h204,      I_SW,    1'b1, 2'b01, 2, 32'h200,      C_MEM,    C_MEM};
        vecs[6]  = '{2'b00, 32'h0,        I_NOP,  32'h0,        I_NOP,   1'b1, 2'b01, 1, 32'h204,      C_MEM,    C_MEM};
        vecs[7]  = '{2'b11, 32'h300,      I_BEQ,  32'h304,      I_ADDIU, 1'b1, 2'b11, 2, 32'h300,      C_BRANCH, C_ALU};
        vecs[8]  = '{2'b11, 32'h400,      I_MTC0, 32'h404,      I_ADDU,  1'b1, 2'b01, 2, 32'h400,      C_SOLO,   C_ALU};
        vecs[9]  = '{2'b00, 32'h0,        I_NOP,  32'h0,        I_NOP,   1'b1, 2'b01, 1, 32'h404,      C_ALU,    C_ALU};
        vecs[10] = '{2'b00, 32'h0,        I_NOP,  32'h0,        I_NOP,   1'b1, 2'b00, 0, 32'h0,        C_ALU,    C_ALU};

        // reset state
        @(negedge clk);
        chk("reset.count", 64'(count), 64'(0));
        chk("reset.issue_valid", 64'(issueValid), 64'(0));
        chk("reset.enq_ready", 64'(enqReady), 64'(1));
        #1 resetn = 1'b1;
        @(negedge clk);

        // directed pairing table
        for (int k = 0; k < 11; k++) begin
            cycle(vecs[k].v, vecs[k].pc0, vecs[k].in0, vecs[k].pc1, vecs[k].in1, vecs[k].dr, 1'b0);
            chk($sformatf("vec%0d.issue_valid", k), 64'(issueValid), 64'(vecs[k].expIv));
            chk($sformatf("vec%0d.count", k), 64'(count), 64'(vecs[k].expCnt));
            if (vecs[k].expIv[0]) begin
                chk($sformatf("vec%0d.pc0", k), 64'(issuePc[31:0]), 64'(vecs[k].expPc0));
                chk($sformatf("vec%0d.class0", k), 64'(issueClass[2:0]), 64'(vecs[k].expC0));
            end
            if (vecs[k].expIv[1])
                chk($sformatf("vec%0d.class1", k), 64'(issueClass[5:3]), 64'(vecs[k].expC1));
        end

        // fill to full, overflow attempt ignored, release one pair, refill across the wrap, drain
        for (int k = 0; k < 8; k++)
            cycle(2'b11, 32'h1000 + 32'(8*k), I_NOP, 32'h1004 + 32'(8*k), I_NOP, 1'b0, 1'b0);
        chk("full.count", 64'(count), 64'(16));
        chk("full.enq_ready", 64'(enqReady), 64'(0));
        cycle(2'b11, 32'hDEAD0000, I_NOP, 32'hDEAD0004, I_NOP, 1'b0, 1'b0);
        chk("full.ignored_count", 64'(count), 64'(16));
        chk("full.head_pc", 64'(issuePc[31:0]), 64'(32'h1000));
        cycle(2'b00, 32'h0, I_NOP, 32'h0, I_NOP, 1'b1, 1'b0);
        chk("release.count", 64'(count), 64'(14));
        chk("release.enq_ready", 64'(enqReady), 64'(1));
        cycle(2'b11, 32'h1040, I_NOP, 32'h1044, I_NOP, 1'b0, 1'b0);
        chk("wrap.count", 64'(count), 64'(16));
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d.issue_valid", k), 64'(issueValid), 64'(2'b11));
            chk($sformatf("drain%0d.pc0", k), 64'(issuePc[31:0]), 64'(32'h1008 + 32'(8*k)));
            chk($sformatf("drain%0d.pc1", k), 64'(issuePc[63:32]), 64'(32'h100C + 32'(8*k)));
            cycle(2'b00, 32'h0, I_NOP, 32'h0, I_NOP, 1'b1, 1'b0);
        end
        chk("drain.count", 64'(count), 64'(0));
        chk("drain.issue_valid", 64'(issueValid), 64'(0));

        // flush wins over a simultaneous enqueue
        for (int k = 0; k < 3; k++)
            cycle(2'b11, 32'h2000 + 32'(8*k), I_ADDU, 32'h2004 + 32'(8*k), I_ORI, 1'b0, 1'b0);
        cycle(2'b01, 32'h2018, I_LW, 32'h0, I_NOP, 1'b0, 1'b0);
        chk("preflush.count", 64'(count), 64'(7));
        cycle(2'b11, 32'h3000, I_ADDU, 32'h3004, I_ADDU, 1'b1, 1'b1);
        chk("flush.count", 64'(count), 64'(0));
        chk("flush.issue_valid", 64'(issueValid), 64'(0));
        chk("flush.enq_ready", 64'(enqReady), 64'(1));

        // asynchronous reset between clock edges
        cycle(2'b11, 32'h4000, I_ADDU, 32'h4004, I_ORI, 1'b0, 1'b0);
        cycle(2'b11, 32'h4008, I_ADDU, 32'h400C, I_ORI, 1'b0, 1'b0);
        chk("prereset.count", 64'(count), 64'(4));
        enqValid = 2'b00;
        #2 resetn = 1'b0;
        #1;
        chk("asyncreset.count", 64'(count), 64'(0));
        chk("asyncreset.issue_valid", 64'(issueValid), 64'(0));
        q.delete();
        #1 resetn = 1'b1;
        @(negedge clk);
        cycle(2'b00, 32'h0, I_NOP, 32'h0, I_NOP, 1'b1, 1'b0);
        chk("postreset.count", 64'(count), 64'(0));

        // randomized traffic against the model, first back-pressured then draining
        pcGen = 32'h8000_0000;
        for (int k = 0; k < 700; k++) begin
            case ($urandom_range(0, 3))
                0:       v = 2'b00;
                1:       v = 2'b01;
                default: v = 2'b11;
            endcase
            dr = (k < 350) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 60) == 0);
            cycle(v, pcGen, genInstr(), pcGen + 32'd4, genInstr(), dr, fl);
            pcGen = pcGen + 32'd8;
            checkModel($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
